// File: rtl/cb_config_loader.sv
// Connection-block config loader: shifts a serial bitstream into 35-bit words,
// validates each routing field and strobes legal words out to one block at a time.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SHIFT  | accepting bits into the shadow word
// CHECK  | validating the five routing fields
// COMMIT | driving the word and write strobe to the selected block
// DONE   | all blocks written, waiting for start
// ERROR  | illegal field found, waiting for start
module cb_config_loader #(
  parameter int NUM_CB = 4,
  parameter int CFG_W  = 35
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [CFG_W-1:0]  cbconfig,
  output logic              cb_we,
  output logic [NUM_CB-1:0] cb_sel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_field,
  output logic [2:0]        err_cb
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [5:0] LAST_BIT = 6'(CFG_W - 1);
  localparam logic [2:0] LAST_BLK = 3'(NUM_CB - 1);

  logic [2:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        blk_q, blk_d;
  logic [CFG_W-1:0]  shadow_q, shadow_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [2:0]        err_field_q, err_field_d;
  logic [2:0]        err_cb_q, err_cb_d;
  logic              bit_ready_q, busy_q, done_q, error_q, cb_we_q;
  logic [NUM_CB-1:0] cb_sel_q;
  logic [4:0]        bad;
  logic [2:0]        first_bad;

  function automatic logic onehot5(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // The output field drives a track, so exactly one LB enable may be set there.
  function automatic logic field_ok(input logic [6:0] f, input logic is_out);
    logic en_ok;
    en_ok = is_out ? (f[6] ^ f[0]) : (f[6] | f[0]);
    return (f == 7'd0) || (onehot5(f[5:1]) && en_ok);
  endfunction

  always_comb begin
    bad       = '0;
    first_bad = '0;
    for (int i = 0; i < 5; i++) begin
      bad[i] = !field_ok(shadow_q[7*i +: 7], i == 4);
    end
    for (int i = 4; i >= 0; i--) begin
      if (bad[i]) first_bad = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    err_field_d = err_field_q;
    err_cb_d    = err_cb_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d     = S_SHIFT;
          cnt_d       = '0;
          blk_d       = '0;
          err_field_d = '0;
          err_cb_d    = '0;
        end
      end
      S_SHIFT: begin
        if (bit_valid && bit_ready_q) begin
          shadow_d = {shadow_q[CFG_W-2:0], bit_in};
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == LAST_BIT) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad != 5'd0) begin
          state_d     = S_ERROR;
          err_field_d = first_bad;
          err_cb_d    = blk_q;
        end else begin
          state_d = S_COMMIT;
          cfg_d   = shadow_q;
        end
      end
      S_COMMIT: begin
        blk_d   = blk_q + 3'd1;
        cnt_d   = '0;
        state_d = (blk_q == LAST_BLK) ? S_DONE : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      err_field_q <= '0;
      err_cb_q    <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cb_we_q     <= 1'b0;
      cb_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      err_field_q <= err_field_d;
      err_cb_q    <= err_cb_d;
      bit_ready_q <= (state_d == S_SHIFT);
      busy_q      <= (state_d == S_SHIFT) || (state_d == S_CHECK) || (state_d == S_COMMIT);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
      cb_we_q     <= (state_d == S_COMMIT);
      cb_sel_q    <= (state_d == S_COMMIT) ? (NUM_CB'(1) << blk_q) : '0;
    end
  end

  assign bit_ready = bit_ready_q;
  assign cbconfig  = cfg_q;
  assign cb_we     = cb_we_q;
  assign cb_sel    = cb_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_field = err_field_q;
  assign err_cb    = err_cb_q;

endmodule
